// File: rtl/ssb_arbiter.sv
// ssb_arbiter: three-host single-slave bus arbiter with starvation promotion.
// Hosts: 0 = debug SBA, 1 = instruction fetch, 2 = data.
// Grants are combinational and zero-wait. The granted command is decoded to
// SRAM, debug memory or unmapped. Every granted access (read or write) gets
// exactly one response one cycle later. An unmapped access returns err=1 and
// rdata=0.
//
// Handshake: a host holds host_req_i with a stable command until it sees
// host_gnt_o in the same cycle. The command is accepted on that clock edge.
// host_rvalid_o/host_err_o/host_rdata_o follow on the next cycle, with no
// backpressure and no reordering.
module ssb_arbiter #(
    parameter logic [31:0] MemStart    = 32'h00000000,
    parameter logic [31:0] MemMask     = 32'h0000FFFF,
    parameter logic [31:0] DbgStart    = 32'h1A110000,
    parameter logic [31:0] DbgMask     = 32'h0000FFFF,
    parameter int unsigned StarveLimit = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  host_req_i,
    input  logic [95:0] host_addr_i,
    input  logic [2:0]  host_we_i,
    input  logic [11:0] host_be_i,
    input  logic [95:0] host_wdata_i,
    output logic [2:0]  host_gnt_o,
    output logic [2:0]  host_rvalid_o,
    output logic [2:0]  host_err_o,
    output logic [31:0] host_rdata_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    output logic        sram_req_o,
    output logic        dbg_req_o,
    input  logic [31:0] sram_rdata_i,
    input  logic [31:0] dbg_rdata_i
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SRAM = 2'd1,
        SEL_DBG  = 2'd2
    } sel_e;

    localparam logic [3:0] StarveLim = 4'(StarveLimit);

    // Starvation counters for instr (host 1) and data (host 2).
    logic [3:0] wait_instr_q, wait_instr_d;
    logic [3:0] wait_data_q,  wait_data_d;

    // Response stage.
    logic       rsp_valid_q, rsp_valid_d;
    logic [1:0] rsp_host_q,  rsp_host_d;
    sel_e       rsp_sel_q,   rsp_sel_d;

    // Grant selection.
    logic       gnt_any;
    logic [1:0] gnt_idx;
    logic       prom_instr;
    logic       prom_data;

    // Muxed command of the granted host.
    logic [31:0] gnt_addr;
    logic        gnt_we;
    logic [3:0]  gnt_be;
    logic [31:0] gnt_wdata;
    logic        hit_sram;
    logic        hit_dbg;

    // Pick one host: debug first, then promoted data, promoted instr, instr, data.
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = 2'd0;
        prom_instr = (wait_instr_q >= StarveLim);
        prom_data  = (wait_data_q  >= StarveLim);
        if (!rst_i) begin
            if (host_req_i[0]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'd0;
            end else if (host_req_i[2] && prom_data) begin
                gnt_any = 1'b1;
                gnt_idx = 2'd2;
            end else if (host_req_i[1] && prom_instr) begin
                gnt_any = 1'b1;
                gnt_idx = 2'd1;
            end else if (host_req_i[1]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'd1;
            end else if (host_req_i[2]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'd2;
            end
        end
    end

    // Route the granted host's command onto the bus. The bus is zero when idle.
    always_comb begin
        gnt_addr  = 32'h0;
        gnt_we    = 1'b0;
        gnt_be    = 4'h0;
        gnt_wdata = 32'h0;
        if (gnt_any) begin
            case (gnt_idx)
                2'd0: begin
                    gnt_addr  = host_addr_i[31:0];
                    gnt_we    = host_we_i[0];
                    gnt_be    = host_be_i[3:0];
                    gnt_wdata = host_wdata_i[31:0];
                end
                2'd1: begin
                    gnt_addr  = host_addr_i[63:32];
                    gnt_we    = host_we_i[1];
                    gnt_be    = host_be_i[7:4];
                    gnt_wdata = host_wdata_i[63:32];
                end
                default: begin
                    gnt_addr  = host_addr_i[95:64];
                    gnt_we    = host_we_i[2];
                    gnt_be    = host_be_i[11:8];
                    gnt_wdata = host_wdata_i[95:64];
                end
            endcase
        end
    end

    // Decode the address. SRAM wins if both regions match.
    // Unmapped addresses select nothing, so unmapped writes have no side effect.
    always_comb begin
        hit_sram = ((gnt_addr & ~MemMask) == MemStart);
        hit_dbg  = ((gnt_addr & ~DbgMask) == DbgStart);
        rsp_valid_d = gnt_any;
        rsp_host_d  = gnt_idx;
        rsp_sel_d   = SEL_NONE;
        if (hit_sram) begin
            rsp_sel_d = SEL_SRAM;
        end else if (hit_dbg) begin
            rsp_sel_d = SEL_DBG;
        end
    end

    // Counters saturate while a requesting host is denied.
    // They clear on a grant or when the request drops.
    always_comb begin
        wait_instr_d = 4'd0;
        wait_data_d  = 4'd0;
        if (host_req_i[1] && !(gnt_any && gnt_idx == 2'd1)) begin
            wait_instr_d = (wait_instr_q == 4'hF) ? 4'hF : wait_instr_q + 4'd1;
        end
        if (host_req_i[2] && !(gnt_any && gnt_idx == 2'd2)) begin
            wait_data_d = (wait_data_q == 4'hF) ? 4'hF : wait_data_q + 4'd1;
        end
    end

    // State registers. Reset drops any pending response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_instr_q <= 4'd0;
            wait_data_q  <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_host_q   <= 2'd0;
            rsp_sel_q    <= SEL_NONE;
        end else begin
            wait_instr_q <= wait_instr_d;
            wait_data_q  <= wait_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_host_q   <= rsp_host_d;
            rsp_sel_q    <= rsp_sel_d;
        end
    end

    // Drive the grant, bus command and device-select outputs.
    always_comb begin
        host_gnt_o  = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
        bus_addr_o  = gnt_addr;
        bus_we_o    = gnt_we;
        bus_be_o    = gnt_be;
        bus_wdata_o = gnt_wdata;
        sram_req_o  = gnt_any && (rsp_sel_d == SEL_SRAM);
        dbg_req_o   = gnt_any && (rsp_sel_d == SEL_DBG);
    end

    // Drive the response for the host granted last cycle.
    always_comb begin
        host_rvalid_o = 3'b000;
        host_err_o    = 3'b000;
        host_rdata_o  = 32'h0;
        if (rsp_valid_q) begin
            host_rvalid_o = 3'b001 << rsp_host_q;
            case (rsp_sel_q)
                SEL_SRAM: host_rdata_o = sram_rdata_i;
                SEL_DBG:  host_rdata_o = dbg_rdata_i;
                default:  host_err_o   = 3'b001 << rsp_host_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ssb_arbiter.sv
// Testbench for ssb_arbiter.
// The reference model uses a rank per host and address ranges. A queue holds
// the expected response.
module tb_ssb_arbiter;

  localparam int STARVE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [2:0]  host_req_i;
  logic [95:0] host_addr_i;
  logic [2:0]  host_we_i;
  logic [11:0] host_be_i;
  logic [95:0] host_wdata_i;
  logic [2:0]  host_gnt_o;
  logic [2:0]  host_rvalid_o;
  logic [2:0]  host_err_o;
  logic [31:0] host_rdata_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        sram_req_o;
  logic        dbg_req_o;
  logic [31:0] sram_rdata_i;
  logic [31:0] dbg_rdata_i;

  ssb_arbiter #(.StarveLimit(STARVE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
    .host_rdata_o(host_rdata_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .sram_req_o(sram_req_o),
    .dbg_req_o(dbg_req_o), .sram_rdata_i(sram_rdata_i), .dbg_rdata_i(dbg_rdata_i)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int m_wait[3];
  logic [3:0] exp_q[$];   // {device(0 none,1 sram,2 dbg), host}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model helpers
  function automatic int dev_of(input logic [31:0] a);
    if (a < 32'h0001_0000) return 1;
    if (a >= 32'h1A11_0000 && a <= 32'h1A11_FFFF) return 2;
    return 0;
  endfunction

  function automatic int pick_winner();
    int best = -1;
    int best_rank = 0;
    int r;
    if (rst_i) return -1;
    for (int h = 0; h < 3; h++) begin
      if (host_req_i[h]) begin
        if (h == 0) r = 100;
        else if (m_wait[h] >= STARVE) r = (h == 2) ? 60 : 50;
        else r = (h == 1) ? 20 : 10;
        if (r > best_rank) begin
          best_rank = r;
          best = h;
        end
      end
    end
    return best;
  endfunction

  // driver tasks
  task automatic set_host(input int h, input logic req, input logic [31:0] addr,
                          input logic we, input logic [3:0] be, input logic [31:0] wd);
    host_req_i[h]          = req;
    host_addr_i[32*h +: 32] = addr;
    host_we_i[h]           = we;
    host_be_i[4*h +: 4]    = be;
    host_wdata_i[32*h +: 32] = wd;
  endtask

  task automatic clear_hosts();
    host_req_i = '0; host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return $urandom & 32'h0000_FFFF;
      1: return 32'h1A11_0000 | ($urandom & 32'h0000_FFFF);
      2: return 32'h2000_0000 + ($urandom & 32'h0000_0FFF);
      default: return $urandom;
    endcase
  endfunction

  // One cycle: inputs were set at negedge. Check at negedge+1, then update the model at posedge.
  task automatic run_cycle(input string tag);
    int w;
    int dev;
    logic [31:0] a;
    logic [3:0] e;
    logic [2:0] ergnt;
    logic [2:0] erv;
    logic [2:0] eerr;
    logic [31:0] erd;
    sram_rdata_i = $urandom;
    dbg_rdata_i  = $urandom;
    #1;
    if (rst_i) begin
      exp_q.delete();
      m_wait[1] = 0;
      m_wait[2] = 0;
    end
    w = pick_winner();
    ergnt = (w < 0) ? 3'b000 : 3'(1 << w);
    a = (w < 0) ? 32'h0 : host_addr_i[32*w +: 32];
    dev = (w < 0) ? 0 : dev_of(a);
    check({tag, "/gnt"}, 32'(host_gnt_o), 32'(ergnt));
    check({tag, "/sram_req"}, 32'(sram_req_o), 32'((w >= 0) && dev == 1));
    check({tag, "/dbg_req"}, 32'(dbg_req_o), 32'((w >= 0) && dev == 2));
    check({tag, "/bus_addr"}, bus_addr_o, a);
    check({tag, "/bus_we"}, 32'(bus_we_o), (w < 0) ? 32'h0 : 32'(host_we_i[w]));
    check({tag, "/bus_be"}, 32'(bus_be_o), (w < 0) ? 32'h0 : 32'(host_be_i[4*w +: 4]));
    check({tag, "/bus_wdata"}, bus_wdata_o, (w < 0) ? 32'h0 : host_wdata_i[32*w +: 32]);
    erv = 3'b000; eerr = 3'b000; erd = 32'h0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      erv = 3'(1 << e[1:0]);
      if (e[3:2] == 2'd1) erd = sram_rdata_i;
      else if (e[3:2] == 2'd2) erd = dbg_rdata_i;
      else eerr = erv;
    end
    check({tag, "/rvalid"}, 32'(host_rvalid_o), 32'(erv));
    check({tag, "/err"}, 32'(host_err_o), 32'(eerr));
    check({tag, "/rdata"}, host_rdata_o, erd);
    @(posedge clk);
    if (!rst_i) begin
      if (w >= 0) exp_q.push_back({2'(dev), 2'(w)});
      for (int h = 1; h < 3; h++) begin
        if (host_req_i[h] && w != h) m_wait[h] = (m_wait[h] < 15) ? m_wait[h] + 1 : 15;
        else m_wait[h] = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    m_wait[0] = 0; m_wait[1] = 0; m_wait[2] = 0;
    rst_i = 1'b1;
    clear_hosts();
    sram_rdata_i = '0; dbg_rdata_i = '0;
    @(negedge clk);

    // Reset: outputs must stay zero even while hosts request.
    set_host(0, 1, 32'h1A11_0000, 0, 4'hF, 32'h1);
    set_host(1, 1, 32'h0000_0100, 1, 4'h3, 32'h2);
    set_host(2, 1, 32'h0000_0200, 0, 4'hF, 32'h3);
    run_cycle("reset0");
    run_cycle("reset1");
    rst_i = 1'b0;
    clear_hosts();

    // Data read to SRAM. The first grant comes right after reset release.
    set_host(2, 1, 32'h0000_0010, 0, 4'hF, 32'h0);
    run_cycle("data_sram_req");
    clear_hosts();
    run_cycle("data_sram_rsp");

    // Debug beats instr. Instr follows once debug drops.
    set_host(0, 1, 32'h1A11_0004, 0, 4'hF, 32'h0);
    set_host(1, 1, 32'h0000_0040, 0, 4'hF, 32'h0);
    run_cycle("dbg_vs_instr");
    set_host(0, 0, 32'h0, 0, 4'h0, 32'h0);
    run_cycle("instr_after_dbg");
    clear_hosts();
    run_cycle("idle0");

    // Starvation: data is promoted on the 5th cycle, then instr resumes.
    set_host(1, 1, 32'h0000_0080, 0, 4'hF, 32'h0);
    set_host(2, 1, 32'h0000_0090, 1, 4'hC, 32'hCAFE_F00D);
    for (int i = 0; i < 8; i++) run_cycle($sformatf("starve%0d", i));
    clear_hosts();
    run_cycle("idle1");

    // Unmapped data read.
    set_host(2, 1, 32'h2000_0000, 0, 4'hF, 32'h0);
    run_cycle("unmapped_req");
    clear_hosts();
    run_cycle("unmapped_rsp");

    // Debug-memory read.
    set_host(0, 1, 32'h1A11_0800, 0, 4'hF, 32'h0);
    run_cycle("dbgmem_req");
    clear_hosts();
    run_cycle("dbgmem_rsp");

    // A reset pulse after a grant drops the pending response.
    set_host(1, 1, 32'h0000_0020, 0, 4'hF, 32'h0);
    run_cycle("pre_reset_gnt");
    clear_hosts();
    set_host(2, 1, 32'h0000_0030, 0, 4'hF, 32'h0);
    rst_i = 1'b1;
    run_cycle("mid_reset");
    rst_i = 1'b0;
    clear_hosts();
    run_cycle("post_reset0");
    run_cycle("post_reset1");

    // Saturation: debug hogs for 18 cycles, so both counters hit 15.
    // Data wins first after debug drops, then instr.
    set_host(0, 1, 32'h1A11_0010, 0, 4'hF, 32'h0);
    set_host(1, 1, 32'h0000_0100, 0, 4'hF, 32'h0);
    set_host(2, 1, 32'h0000_0200, 0, 4'hF, 32'h0);
    for (int i = 0; i < 18; i++) run_cycle($sformatf("sat%0d", i));
    set_host(0, 0, 32'h0, 0, 4'h0, 32'h0);
    run_cycle("sat_release0");
    run_cycle("sat_release1");
    clear_hosts();
    run_cycle("idle2");

    // Randomized phases. The debug request probability rises to provoke double promotion.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int pdbg;
        pdbg = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
        for (int h = 0; h < 3; h++) begin
          logic r;
          r = (h == 0) ? ($urandom_range(0, 99) < pdbg) : ($urandom_range(0, 99) < 75);
          set_host(h, r, rand_addr(), 1'($urandom), 4'($urandom), $urandom);
        end
        if ($urandom_range(0, 299) == 0) rst_i = 1'b1;
        run_cycle($sformatf("rand%0d_%0d", ph, i));
        rst_i = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssb_arbiter.md
SSB_ARBITER -- requirements
Module: ssb_arbiter

Interface
REQ-001 Parameter MemStart, default 32'h00000000, SRAM base address.
REQ-002 Parameter MemMask, default 32'h0000FFFF, SRAM offset mask (64 kB).
REQ-003 Parameter DbgStart, default 32'h1A110000, debug-memory base address.
REQ-004 Parameter DbgMask, default 32'h0000FFFF, debug-memory offset mask.
REQ-005 Parameter StarveLimit, default 4, range 1-15; consecutive denied cycles before a host is promoted.
REQ-006 clk_i  in  1  system clock; single clock domain.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 host_req_i  in  3  request per host; index 0 = debug SBA, 1 = instr, 2 = data.
REQ-009 host_addr_i  in  96  byte address per host, host h at [32h+31:32h].
REQ-010 host_we_i  in  3  write enable per host.
REQ-011 host_be_i  in  12  byte enables per host, host h at [4h+3:4h].
REQ-012 host_wdata_i  in  96  write data per host.
REQ-013 host_gnt_o  out  3  grant, one-hot or zero.
REQ-014 host_rvalid_o  out  3  response valid, one-hot or zero.
REQ-015 host_err_o  out  3  response error, valid with host_rvalid_o.
REQ-016 host_rdata_o  out  32  read data, shared by all hosts.
REQ-017 bus_addr_o / bus_we_o / bus_be_o / bus_wdata_o  out  32/1/4/32  muxed command to devices.
REQ-018 sram_req_o, dbg_req_o  out  1 each  device selects.
REQ-019 sram_rdata_i, dbg_rdata_i  in  32 each  device read data, one cycle after request.

Function
REQ-020 Arbitration SHALL be combinational: at most one grant per cycle, issued same cycle as request; zero-wait whenever any host_req_i is high.
REQ-021 Base priority SHALL be debug > instr > data.
REQ-022 Per-host 4-bit saturating counters wait_cnt[1], wait_cnt[2] SHALL increment each cycle that host requests and is not granted, clear on grant or on deasserted request.
REQ-023 A host with wait_cnt >= StarveLimit SHALL be promoted above instr and data (never above debug); both promoted -> data wins.
REQ-024 With no grant, bus_* outputs SHALL be zero and both device selects low.
REQ-025 Decode: sram_req_o = grant & ((addr & ~MemMask) == MemStart); dbg_req_o likewise with DbgStart/DbgMask; both matching -> SRAM only.
REQ-026 Granted address matching neither region SHALL drive no device req and SHALL be flagged unmapped.
REQ-027 Response stage SHALL register granted host index, device select (SRAM/DBG/NONE) and valid; next cycle asserts host_rvalid_o for that host only.
REQ-028 host_rdata_o SHALL be sram_rdata_i, dbg_rdata_i or 32'h0 per the registered select; 32'h0 when no response pending.
REQ-029 Unmapped response: host_err_o high for that host, rdata 32'h0; writes to unmapped addresses have no device side effect.
REQ-030 Writes SHALL also return rvalid one cycle after grant, err=0 when mapped.
REQ-031 Back-to-back grants every cycle SHALL be supported; latency fixed at 1 cycle, no response reordering.

Reset
REQ-032 While rst_i high: host_gnt_o, host_rvalid_o, host_err_o = 0; host_rdata_o = 0; device reqs low; wait counters 0; response stage invalid.
REQ-033 Reset asserted mid-transaction SHALL drop the pending response; no rvalid after release for pre-reset grants.
REQ-034 First grant possible in the first cycle after rst_i falls.

Verification
REQ-035 Only data req, addr 32'h00000010 read -> gnt=3'b100 same cycle, sram_req_o=1; next cycle rvalid=3'b100, err=0, rdata=sram_rdata_i.
REQ-036 Debug and instr request same cycle -> gnt=3'b001; instr granted next cycle if debug drops.
REQ-037 Instr held high, data held high, StarveLimit=4 -> data granted on 5th cycle, then instr resumes; wait_cnt[2] returns 0.
REQ-038 Data read to 32'h20000000 -> no device req; next cycle rvalid=3'b100, err=3'b100, rdata=32'h0.
REQ-039 Debug read 32'h1A110800 -> dbg_req_o=1; next cycle rdata=dbg_rdata_i to host 0.
REQ-040 rst_i pulsed one cycle after a grant -> no rvalid afterwards; all outputs 0 during reset.
